// File: rtl/resp_demux2_pkg.sv
// resp_demux2_pkg -- shared constants for the resp_demux2 response steering block.
// Revision: 1.0
`default_nettype none

package resp_demux2_pkg;
  localparam int   DEFAULT_WIDTH = 32;
  localparam logic SEL_OP1       = 1'b0;
  localparam logic SEL_OP2       = 1'b1;
endpackage

`default_nettype wire

// File: rtl/resp_demux2_fifo.sv
// demux_fifo -- per-output buffer with head-of-queue read port and count-based full/empty.
// Revision: 1.0
`default_nettype none

module demux_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: rtl/resp_demux2.sv
// resp_demux2 -- 1-to-2 response demux with a FIFO per output; RESP_DEMUX_BYPASS_EN adds an empty-FIFO bypass.
// Revision: 1.0
`default_nettype none

module resp_demux2
  import resp_demux2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             op1_valid,
  input  logic             op1_ready,
  output logic [WIDTH-1:0] op1_data,
  output logic             op2_valid,
  input  logic             op2_ready,
  output logic [WIDTH-1:0] op2_data
);
  logic             full1, full2, empty1, empty2;
  logic             fire1, fire2, push1, push2, pop1, pop2;
  logic [WIDTH-1:0] head1, head2;

  // Ready looks only at the selected FIFO's registered count, never at op*_ready.
  assign in_ready = !rst && ((in_sel == SEL_OP2) ? !full2 : !full1);
  assign fire1    = in_valid && in_ready && (in_sel == SEL_OP1);
  assign fire2    = in_valid && in_ready && (in_sel == SEL_OP2);
  assign pop1     = !empty1 && op1_ready;
  assign pop2     = !empty2 && op2_ready;

`ifdef RESP_DEMUX_BYPASS_EN
  logic byp1, byp2;
  assign byp1      = fire1 && empty1 && op1_ready;
  assign byp2      = fire2 && empty2 && op2_ready;
  assign push1     = fire1 && !byp1;
  assign push2     = fire2 && !byp2;
  assign op1_valid = !empty1 || byp1;
  assign op2_valid = !empty2 || byp2;
  assign op1_data  = byp1 ? in_data : head1;
  assign op2_data  = byp2 ? in_data : head2;
`else
  assign push1     = fire1;
  assign push2     = fire2;
  assign op1_valid = !empty1;
  assign op2_valid = !empty2;
  assign op1_data  = head1;
  assign op2_data  = head2;
`endif

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (in_data),
    .full      (full1),
    .pop       (pop1),
    .head_data (head1),
    .empty     (empty1)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
    .clk       (clk),
    .rst       (rst),
    .push      (push2),
    .push_data (in_data),
    .full      (full2),
    .pop       (pop2),
    .head_data (head2),
    .empty     (empty2)
  );
endmodule

`default_nettype wire

// File: tb/tb_resp_demux2.sv
// tb_resp_demux2 -- scoreboard bench for resp_demux2 with per-output reference queues.
// Revision: 1.0
`default_nettype none

module tb_resp_demux2;
  localparam int DEPTH = 2;
`ifdef RESP_DEMUX_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sel = 1'b0;
  logic [31:0] in_data = '0;
  logic        op1_valid, op2_valid;
  logic        op1_ready = 1'b0, op2_ready = 1'b0;
  logic [31:0] op1_data, op2_data;

  beat_t exp_q[2][$];
  int    cyc = 0;
  int    n_chk = 0, n_fail = 0;
  int    sent = 0, recv = 0, discarded = 0;
  bit    rand_bp = 1'b0;

  resp_demux2 #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .op1_valid (op1_valid),
    .op1_ready (op1_ready),
    .op1_data  (op1_data),
    .op2_valid (op2_valid),
    .op2_ready (op2_ready),
    .op2_data  (op2_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Input side: model ready from outstanding-beat counts and record accepted beats.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk(in_ready == 1'b0, "in_ready_in_reset", 32'(in_ready), 32'd0);
    end else if (in_valid) begin
      chk(in_ready == (exp_q[in_sel].size() < DEPTH), "in_ready",
          32'(in_ready), 32'(exp_q[in_sel].size() < DEPTH));
      if (in_ready) begin
        exp_q[in_sel].push_back('{data: in_data, cyc: cyc});
        sent++;
      end
    end
  end

  // Output side: compare each presented head against the reference queues.
  initial begin
    bit          prev_hold [2];
    logic [31:0] prev_data [2];
    prev_hold = '{1'b0, 1'b0};
    prev_data = '{32'd0, 32'd0};
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        discarded += exp_q[0].size() + exp_q[1].size();
        exp_q[0].delete();
        exp_q[1].delete();
        prev_hold = '{1'b0, 1'b0};
      end else begin
        for (int n = 0; n < 2; n++) begin
          logic        v, r, ev;
          logic [31:0] d;
          v  = (n == 0) ? op1_valid : op2_valid;
          r  = (n == 0) ? op1_ready : op2_ready;
          d  = (n == 0) ? op1_data  : op2_data;
          ev = 1'b0;
          if (exp_q[n].size() > 0)
            ev = (exp_q[n][0].cyc < cyc) || (BYP && r && exp_q[n][0].cyc == cyc);
          chk(v == ev, (n == 0) ? "op1_valid" : "op2_valid", 32'(v), 32'(ev));
          if (v && ev)
            chk(d == exp_q[n][0].data, (n == 0) ? "op1_data" : "op2_data", d, exp_q[n][0].data);
          if (prev_hold[n]) begin
            chk(v == 1'b1, (n == 0) ? "op1_valid_hold" : "op2_valid_hold", 32'(v), 32'd1);
            chk(d == prev_data[n], (n == 0) ? "op1_data_hold" : "op2_data_hold", d, prev_data[n]);
          end
          prev_hold[n] = v && !r;
          prev_data[n] = d;
          if (v && r && exp_q[n].size() > 0) begin
            void'(exp_q[n].pop_front());
            recv++;
          end
        end
      end
    end
  end

  // Random backpressure on both consumers (about 30% stalled).
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_bp) begin
      op1_ready = ($urandom_range(0, 99) >= 30);
      op2_ready = ($urandom_range(0, 99) >= 30);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic s, input logic [31:0] d);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk(1'b0, "send_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    @(negedge clk);
    chk(op1_valid == 1'b0, {tag, "_op1_valid"}, 32'(op1_valid), 32'd0);
    chk(op2_valid == 1'b0, {tag, "_op2_valid"}, 32'(op2_valid), 32'd0);
    chk(op1_data == 32'd0, {tag, "_op1_data"}, op1_data, 32'd0);
    chk(op2_data == 32'd0, {tag, "_op2_data"}, op2_data, 32'd0);
    chk(in_ready == 1'b1, {tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    chk_idle_outputs("por");
    tick();

    // Basic routing.
    op1_ready = 1'b1;
    op2_ready = 1'b1;
    send(1'b0, 32'hDEADBEEF);
    send(1'b1, 32'h12345678);
    idle(3);

    // Reset with one beat held in each FIFO.
    op1_ready = 1'b0;
    op2_ready = 1'b0;
    send(1'b0, 32'h11111111);
    send(1'b1, 32'h22222222);
    idle(1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk_idle_outputs("midrst");
    tick();

    // Independence: op1 stalled and full, op2 keeps flowing.
    op1_ready = 1'b0;
    op2_ready = 1'b1;
    send(1'b0, 32'hA1A1A1A1);
    send(1'b0, 32'hA2A2A2A2);
    in_sel = 1'b0;
    @(negedge clk);
    chk(in_ready == 1'b0, "indep_ready_sel0", 32'(in_ready), 32'd0);
    tick();
    in_sel = 1'b1;
    @(negedge clk);
    chk(in_ready == 1'b1, "indep_ready_sel1", 32'(in_ready), 32'd1);
    tick();
    send(1'b1, 32'h0000000A);
    send(1'b1, 32'h0000000B);
    send(1'b1, 32'h0000000C);
    idle(4);
    chk(exp_q[1].size() == 0, "indep_op2_drained", 32'(exp_q[1].size()), 32'd0);
    op1_ready = 1'b1;
    idle(4);

    // Full FIFO with a simultaneous pop costs exactly one bubble.
    op2_ready = 1'b0;
    send(1'b1, 32'hF0000001);
    send(1'b1, 32'hF0000002);
    op2_ready = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 1'b1;
    in_data   = 32'hF0000003;
    @(negedge clk);
    chk(in_ready == 1'b0, "fullpop_ready_first", 32'(in_ready), 32'd0);
    tick();
    @(negedge clk);
    chk(in_ready == 1'b1, "fullpop_ready_next", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    idle(4);

    // Empty op1 with ready: same-cycle with bypass, next cycle otherwise.
    op1_ready = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 1'b0;
    in_data   = 32'h5A5A5A5A;
    @(negedge clk);
    chk(op1_valid == BYP, "byp_valid_same", 32'(op1_valid), 32'(BYP));
    if (BYP) chk(op1_data == 32'h5A5A5A5A, "byp_data_same", op1_data, 32'h5A5A5A5A);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk(op1_valid == !BYP, "byp_valid_next", 32'(op1_valid), 32'(!BYP));
    if (!BYP) chk(op1_data == 32'h5A5A5A5A, "byp_data_next", op1_data, 32'h5A5A5A5A);
    idle(4);

    // Random traffic with backpressure, exercising pointer wrap.
    rand_bp = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send(1'($urandom_range(0, 1)), $urandom);
    end
    rand_bp = 1'b0;
    idle(1);
    op1_ready = 1'b1;
    op2_ready = 1'b1;
    idle(10);
    chk(exp_q[0].size() == 0, "drain_op1", 32'(exp_q[0].size()), 32'd0);
    chk(exp_q[1].size() == 0, "drain_op2", 32'(exp_q[1].size()), 32'd0);
    chk(sent == recv + discarded, "beat_conservation", 32'(recv + discarded), 32'(sent));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire

// File: doc/resp_demux2.md
Name: resp_demux2

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshakes on all three sides.
- One 32-bit producer stream is steered by a per-beat select bit to one of two consumers, e.g. memory responses routed to the fetch unit or the load/store unit.
- Each output has its own small FIFO, so a stalled consumer does not block beats bound for the other output.
- It performs the inverse of the datapath 2:1 output selector.

Parameters:
- WIDTH, 32, data width of every beat.
- DEPTH, 2, entries per output FIFO; power of two, >= 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  beat is accepted this cycle.
- in_sel  input  1  routing bit: 0 sends to op1, 1 sends to op2; valid with in_valid.
- in_data  input  WIDTH  beat payload.
- op1_valid  output  1  op1 FIFO head is valid.
- op1_ready  input  1  consumer 1 takes the head.
- op1_data  output  WIDTH  op1 FIFO head.
- op2_valid  output  1  op2 FIFO head is valid.
- op2_ready  input  1  consumer 2 takes the head.
- op2_data  output  WIDTH  op2 FIFO head.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. Everything samples on the rising edge of clk.
- Reset (rst=1 at an edge):
  - all FIFO pointers and counts go to 0; storage goes to 0.
  - op1_valid=0, op2_valid=0, op1_data=0, op2_data=0.
  - in_ready=0 while rst is high.
  - Reset mid-transfer discards every buffered beat, with no partial delivery.
- Acceptance:
  - in_ready = !rst && !full(selected FIFO), where the FIFO is selected by in_sel.
  - in_ready is combinational on in_sel and registered counts only. It never depends on op*_ready, so there is no ready-through path.
  - A beat transfers when in_valid && in_ready.
  - A full FIFO with a simultaneous pop still deasserts in_ready. This costs one bubble and is intentional.
- Output side:
  - opN_valid = (countN != 0).
  - opN_data = storage[rd_ptrN].
  - A pop happens on opN_valid && opN_ready.
- Latency: a beat accepted at edge k is visible on opN_valid/opN_data after edge k (one cycle, registered).
- Ordering: FIFO order is kept within each output. There is no ordering guarantee between op1 and op2.
- Counts: each count is clog2(DEPTH)+1 bits, range 0..DEPTH.
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged, with both pointers advancing.
- Pointers: wr_ptr and rd_ptr are clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- Protocol rules (checked by assertions in the bench):
  - A producer holding in_valid must keep in_data and in_sel stable until accepted.
  - opN_valid, once asserted, stays high and opN_data stays stable until popped.
  - Pushing into a full FIFO or popping an empty FIFO cannot occur by construction.
- No state machine beyond the FIFO counters. The block is stateless apart from the buffers.

Optional Feature:
- Macro: RESP_DEMUX_BYPASS_EN.
- Defined: when the selected FIFO is empty and its opN_ready=1, an accepted beat goes combinationally to opN_valid/opN_data in the same cycle and is not written into the FIFO.
  - Latency becomes 0 for this case.
  - in_ready is unchanged.
  - opN_valid may then depend combinationally on in_valid and in_sel.
- Undefined: always registered, latency 1, and no combinational path from input to output.

Decomposition:
- Shared package holds:
  - the default WIDTH (32);
  - localparams SEL_OP1=1'b0 and SEL_OP2=1'b1.
- One sub-module, demux_fifo:
  - parameters WIDTH and DEPTH;
  - ports clk, rst, push, push_data, full, pop, head_data, empty.
- It is instantiated twice, once per output. The top level holds only the steering and ready logic.

Test Plan:
- Reset: assert rst for 2 cycles mid-stream with 1 beat in each FIFO -> after release op1_valid=0, op2_valid=0, op*_data=0, in_ready=1 on the first non-reset cycle.
- Basic routing: send 0xDEADBEEF with sel=0, then 0x12345678 with sel=1, with op*_ready=1 -> op1 shows 0xDEADBEEF one cycle after acceptance, op2 shows 0x12345678 one cycle after its acceptance, and the other output stays invalid.
- Independence: hold op1_ready=0 and send 2 beats to op1 -> in_ready=0 for sel=0 but 1 for sel=1. Three beats to op2 (0xA, 0xB, 0xC) all drain in order while op1 holds its first beat stable.
- Full with simultaneous pop: op2 full (DEPTH=2), op2_ready=1, in_valid with sel=1 -> in_ready=0 that cycle and 1 the next. No beat is lost or duplicated.
- Wrap-around: 1000 random beats, random in_sel, random 30% backpressure on each output -> the scoreboard shows per-output order preserved, and the counts of beats sent equal the counts received.
- Bypass (RESP_DEMUX_BYPASS_EN): empty op1, op1_ready=1, send 0x5A5A5A5A with sel=0 -> op1_valid=1 and data match in the same cycle. Without the macro they appear one cycle later.
